fetch_redirect_ctrl: RTL and testbench
======================================

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 0, boot PC of width INSTRUCTION_ADDR_WIDTH (IAW).
REQ-002 SHALL have one clock and a synchronous, active-low reset, named clk_in and rst_low_in.
REQ-003 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_low_in  input  1  synchronous active-low reset.
REQ-005 fetch_pc_out  output  IAW  PC value driven to the fetcher's pc_in.
REQ-006 fetch_set_pc_out  output  1  load strobe to the fetcher's set_pc_in.
REQ-007 fetch_instr_in  input  32  fetched instruction word.
REQ-008 fetch_instr_pc_in  input  IAW  PC of the fetched word.
REQ-009 fetch_instr_valid_in  input  1  fetched word valid.
REQ-010 trap_req_in  input  1  trap redirect request; trap_target_in  input  IAW  trap handler address.
REQ-011 branch_req_in  input  1  taken branch/jump; branch_target_in  input  IAW  branch target.
REQ-012 dec_instr_out  output  instr_u  instruction to decode; dec_pc_out  output  IAW  its PC.
REQ-013 dec_valid_out  output  1  decode register valid; dec_ready_in  input  1  decode accepts.
REQ-014 misalign_err_out  output  1  one-cycle pulse: redirect target had bits[1:0] != 0.
REQ-015 redirect_count_out  output  16  saturating count of redirects taken.

Function
REQ-016 SHALL implement states BOOT, RUN, STALL in a registered state machine.
REQ-017 BOOT: SHALL drive fetch_set_pc_out=1, fetch_pc_out=RESET_VECTOR, expected_pc<=RESET_VECTOR, then go to RUN; lasts exactly one cycle.
REQ-018 RUN: a fetched word SHALL be accepted only if fetch_instr_valid_in=1 and fetch_instr_pc_in==expected_pc; otherwise it is silently dropped (stale).
REQ-019 Accept SHALL load dec_instr_out/dec_pc_out, set dec_valid_out next cycle, and advance expected_pc by DATA_BYTES, wrapping modulo 2^IAW.
REQ-020 dec_valid_out SHALL clear on the cycle after dec_ready_in=1 unless a new word is accepted that cycle (back-to-back throughput one instruction per cycle).
REQ-021 If dec_valid_out=1, dec_ready_in=0 and an acceptable word arrives, SHALL not accept it, drive fetch_set_pc_out=1 with fetch_pc_out=expected_pc (refetch), and go to STALL.
REQ-022 STALL: SHALL hold the decode register, drive fetch_set_pc_out=1, fetch_pc_out=expected_pc every cycle; on dec_ready_in=1 deassert set_pc that cycle and return to RUN.
REQ-023 Redirect (trap_req_in or branch_req_in, in RUN or STALL): SHALL drive fetch_set_pc_out=1, fetch_pc_out=target with bits[1:0] cleared, expected_pc<=same value, clear dec_valid_out, go to RUN.
REQ-024 Simultaneous trap and branch: trap SHALL win; branch is discarded.
REQ-025 Redirect SHALL take priority over stall, accept and refetch in the same cycle.
REQ-026 misalign_err_out SHALL pulse one cycle after a taken redirect whose target[1:0] != 0.
REQ-027 redirect_count_out SHALL increment per taken redirect, saturating at 16'hFFFF; BOOT is not counted.
REQ-028 Redirect requests during BOOT SHALL be ignored.
REQ-029 fetch_pc_out SHALL equal expected_pc whenever fetch_set_pc_out=0.

Reset
REQ-030 On rst_low_in=0 at a clock edge: state<=BOOT, expected_pc<=0, dec_valid_out<=0, dec_instr_out<=0, dec_pc_out<=0, misalign_err_out<=0, redirect_count_out<=0.
REQ-031 During reset fetch_set_pc_out SHALL be 0; reset mid-stall or mid-redirect SHALL discard all pending state.

Structure
REQ-032 INSTRUCTION_ADDR_WIDTH, DATA_BYTES SHALL come from memory_system_pkg; instr_u from risc_v_isa_pkg.
REQ-033 State enum fetch_ctrl_state_e SHALL live in a shared processor package.
REQ-034 SHALL be a single module with no sub-modules; RTL size 120-400 lines.

Verification
REQ-035 Release reset, RESET_VECTOR=0x40, dec_ready_in=1 -> set_pc pulse with 0x40, then dec_pc_out 0x40, 0x44, 0x48 on consecutive cycles.
REQ-036 Branch to 0x100 while fetcher streams 0x50 -> dec_valid_out cleared, words 0x54/0x58 dropped, next dec_pc_out=0x100, redirect_count_out=1.
REQ-037 trap_req_in (0x200) and branch_req_in (0x300) same cycle -> fetch_pc_out=0x200, next dec_pc_out=0x200.
REQ-038 dec_ready_in=0 for 5 cycles holding 0x10 -> STALL, set_pc=1 with 0x14 each cycle; on release dec_pc_out 0x14 follows, no loss or duplicate.
REQ-039 Branch to 0x103 -> misalign_err_out one-cycle pulse, fetch_pc_out=0x100; 65540 redirects -> redirect_count_out=16'hFFFF.
REQ-040 Reset asserted during STALL -> all outputs zero next edge, BOOT sequence repeats.

Source files
------------

// File: rtl/fetch_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl_pkg
// Purpose : Shared processor types for the fetch front end: the fetch
//           control state encoding and a PC alignment helper.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package fetch_redirect_ctrl_pkg;

  import memory_system_pkg::*;

  // BOOT loads the reset vector, RUN streams words into decode, STALL keeps
  // the fetcher parked on the next expected PC while decode is full.
  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_STALL = 2'd2
  } fetch_ctrl_state_e;

  // Redirect targets are forced onto a word boundary before use.
  function automatic logic [INSTRUCTION_ADDR_WIDTH-1:0] word_align(
    input logic [INSTRUCTION_ADDR_WIDTH-1:0] addr
  );
    return {addr[INSTRUCTION_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/memory_system_pkg.sv
// ---------------------------------------------------------------------------
// memory_system_pkg
// Purpose : Address-space and access-size constants shared by the fetch path
//           and the memory system.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package memory_system_pkg;

  // Width of every instruction address (PC) in the processor.
  localparam int INSTRUCTION_ADDR_WIDTH = 32;

  // Bytes per fetched instruction word; the sequential PC step.
  localparam int DATA_BYTES = 4;

endpackage

// File: rtl/risc_v_isa_pkg.sv
// ---------------------------------------------------------------------------
// risc_v_isa_pkg
// Purpose : RISC-V instruction word view shared by fetch and decode.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package risc_v_isa_pkg;

  // Generic R-type field split; other formats reuse the same bit positions
  // for opcode/rd/funct3/rs1/rs2.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_type_t;

  // A 32-bit instruction word, viewable raw or as decoded fields.
  typedef union packed {
    logic [31:0] raw;
    r_type_t     r;
  } instr_u;

endpackage

// File: rtl/fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl
// Purpose : Sits between the instruction fetcher and decode. Tracks the PC
//           the front end expects next, filters stale fetched words, holds
//           one instruction for decode, parks the fetcher while decode is
//           full, and steers the fetcher on trap/branch redirects.
// Ports   :
//   clk_in, rst_low_in            clock, synchronous active-low reset
//   fetch_pc_out/fetch_set_pc_out PC and load strobe to the fetcher
//   fetch_instr_*_in              fetched word, its PC and valid
//   trap_req_in/trap_target_in    trap redirect (wins over branch)
//   branch_req_in/branch_target_in taken branch/jump redirect
//   dec_instr_out/dec_pc_out      decode register contents
//   dec_valid_out/dec_ready_in    decode handshake
//   misalign_err_out              pulse after a redirect to a misaligned target
//   redirect_count_out            saturating count of taken redirects
// ---------------------------------------------------------------------------
module fetch_redirect_ctrl
  import memory_system_pkg::*;
  import risc_v_isa_pkg::*;
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [INSTRUCTION_ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                              clk_in,
  input  logic                              rst_low_in,
  output logic [INSTRUCTION_ADDR_WIDTH-1:0] fetch_pc_out,
  output logic                              fetch_set_pc_out,
  input  logic [31:0]                       fetch_instr_in,
  input  logic [INSTRUCTION_ADDR_WIDTH-1:0] fetch_instr_pc_in,
  input  logic                              fetch_instr_valid_in,
  input  logic                              trap_req_in,
  input  logic [INSTRUCTION_ADDR_WIDTH-1:0] trap_target_in,
  input  logic                              branch_req_in,
  input  logic [INSTRUCTION_ADDR_WIDTH-1:0] branch_target_in,
  output instr_u                            dec_instr_out,
  output logic [INSTRUCTION_ADDR_WIDTH-1:0] dec_pc_out,
  output logic                              dec_valid_out,
  input  logic                              dec_ready_in,
  output logic                              misalign_err_out,
  output logic [15:0]                       redirect_count_out
);

  localparam int IAW = INSTRUCTION_ADDR_WIDTH;
  localparam logic [IAW-1:0] PC_STEP = IAW'(DATA_BYTES);

  fetch_ctrl_state_e state_q, state_d;
  logic [IAW-1:0]    expectedPc_q, expectedPc_d;
  logic [IAW-1:0]    decPc_q, decPc_d;
  instr_u            decInstr_q, decInstr_d;
  logic              decValid_q, decValid_d;
  logic              misalign_q, misalign_d;
  logic [15:0]       redirectCount_q, redirectCount_d;

  logic              inFlight;
  logic              wordMatches;
  logic              decodeBlocked;
  logic              takeRedirect;
  logic              acceptWord;
  logic              refetch;
  logic [IAW-1:0]    rawTarget;
  logic [IAW-1:0]    alignedTarget;

  // Arbitration between redirect, accept and refetch. Redirect beats
  // everything; trap beats branch. In STALL the decode register is always
  // full, so "blocked" reduces to !dec_ready_in and the fetcher stays parked
  // regardless of what it presents.
  always_comb begin
    inFlight      = (state_q == FETCH_RUN) || (state_q == FETCH_STALL);
    rawTarget     = trap_req_in ? trap_target_in : branch_target_in;
    alignedTarget = word_align(rawTarget);
    wordMatches   = fetch_instr_valid_in && (fetch_instr_pc_in == expectedPc_q);
    decodeBlocked = decValid_q && !dec_ready_in;
    takeRedirect  = inFlight && (trap_req_in || branch_req_in);
    acceptWord    = inFlight && !takeRedirect && wordMatches && !decodeBlocked;
    refetch       = inFlight && !takeRedirect && decodeBlocked &&
                    ((state_q == FETCH_STALL) || wordMatches);
  end

  // Next-state computation for the control FSM and the decode register.
  always_comb begin
    state_d         = state_q;
    expectedPc_d    = expectedPc_q;
    decPc_d         = decPc_q;
    decInstr_d      = decInstr_q;
    decValid_d      = decValid_q;
    misalign_d      = 1'b0;
    redirectCount_d = redirectCount_q;

    if (state_q == FETCH_BOOT) begin
      expectedPc_d = RESET_VECTOR;
      state_d      = FETCH_RUN;
    end else if (takeRedirect) begin
      // Anything already in decode belongs to the abandoned path.
      expectedPc_d = alignedTarget;
      decValid_d   = 1'b0;
      misalign_d   = |rawTarget[1:0];
      state_d      = FETCH_RUN;
      if (redirectCount_q != 16'hFFFF) begin
        redirectCount_d = redirectCount_q + 16'd1;
      end
    end else if (acceptWord) begin
      decInstr_d   = fetch_instr_in;
      decPc_d      = fetch_instr_pc_in;
      decValid_d   = 1'b1;
      expectedPc_d = expectedPc_q + PC_STEP;
      state_d      = FETCH_RUN;
    end else if (refetch) begin
      state_d = FETCH_STALL;
    end else begin
      state_d = FETCH_RUN;
      if (dec_ready_in) begin
        decValid_d = 1'b0;
      end
    end
  end

  // Fetcher steering. Whenever no load is requested the fetcher sees the
  // expected PC, so the PC bus never carries a stale target.
  always_comb begin
    fetch_set_pc_out = 1'b0;
    fetch_pc_out     = expectedPc_q;
    if (rst_low_in) begin
      if (state_q == FETCH_BOOT) begin
        fetch_set_pc_out = 1'b1;
        fetch_pc_out     = RESET_VECTOR;
      end else if (takeRedirect) begin
        fetch_set_pc_out = 1'b1;
        fetch_pc_out     = alignedTarget;
      end else if (refetch) begin
        fetch_set_pc_out = 1'b1;
      end
    end
  end

  // Single state register bank; reset discards any pending stall/redirect.
  always_ff @(posedge clk_in) begin
    if (!rst_low_in) begin
      state_q         <= FETCH_BOOT;
      expectedPc_q    <= '0;
      decPc_q         <= '0;
      decInstr_q      <= '0;
      decValid_q      <= 1'b0;
      misalign_q      <= 1'b0;
      redirectCount_q <= '0;
    end else begin
      state_q         <= state_d;
      expectedPc_q    <= expectedPc_d;
      decPc_q         <= decPc_d;
      decInstr_q      <= decInstr_d;
      decValid_q      <= decValid_d;
      misalign_q      <= misalign_d;
      redirectCount_q <= redirectCount_d;
    end
  end

  assign dec_instr_out      = decInstr_q;
  assign dec_pc_out         = decPc_q;
  assign dec_valid_out      = decValid_q;
  assign misalign_err_out   = misalign_q;
  assign redirect_count_out = redirectCount_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_ctrl
// Purpose : Self-checking bench for fetch_redirect_ctrl with a small
//           behavioural fetcher and a queue of expected decode PCs.
// ---------------------------------------------------------------------------
module tb_fetch_redirect_ctrl;
  import risc_v_isa_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_low_in;
  logic [31:0] fetch_pc_out;
  logic        fetch_set_pc_out;
  logic [31:0] fetch_instr_in;
  logic [31:0] fetch_instr_pc_in;
  logic        fetch_instr_valid_in;
  logic        trap_req_in;
  logic [31:0] trap_target_in;
  logic        branch_req_in;
  logic [31:0] branch_target_in;
  instr_u      dec_instr_out;
  logic [31:0] dec_pc_out;
  logic        dec_valid_out;
  logic        dec_ready_in;
  logic        misalign_err_out;
  logic [15:0] redirect_count_out;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] sbq[$];

  // Fetcher model: presents fpc while enabled and not at fetchStop; a load
  // takes effect after fetchLag extra cycles of stale sequential words.
  logic [31:0] fpc, fetchStop, pendPc;
  int          fetchLag, pendLag;
  logic        pendValid, fetchOn;

  fetch_redirect_ctrl #(.RESET_VECTOR(32'h40)) dut (
    .clk_in(clk_in), .rst_low_in(rst_low_in),
    .fetch_pc_out(fetch_pc_out), .fetch_set_pc_out(fetch_set_pc_out),
    .fetch_instr_in(fetch_instr_in), .fetch_instr_pc_in(fetch_instr_pc_in),
    .fetch_instr_valid_in(fetch_instr_valid_in),
    .trap_req_in(trap_req_in), .trap_target_in(trap_target_in),
    .branch_req_in(branch_req_in), .branch_target_in(branch_target_in),
    .dec_instr_out(dec_instr_out), .dec_pc_out(dec_pc_out),
    .dec_valid_out(dec_valid_out), .dec_ready_in(dec_ready_in),
    .misalign_err_out(misalign_err_out), .redirect_count_out(redirect_count_out)
  );

  // Free-running clock.
  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] wordFor(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0013;
  endfunction

  task automatic driveFetch();
    fetch_instr_pc_in    = fpc;
    fetch_instr_in       = wordFor(fpc);
    fetch_instr_valid_in = fetchOn && (fpc != fetchStop);
  endtask

  // One clock: samples the handshake and fetcher strobe before the edge,
  // then advances the fetcher model just after it.
  task automatic applyStimulus(output logic hs, output logic [31:0] hsPc,
                               output logic [31:0] hsInstr);
    logic        setPc, presented;
    logic [31:0] pcOut;
    @(negedge clk_in);
    hs        = dec_valid_out && dec_ready_in;
    hsPc      = dec_pc_out;
    hsInstr   = dec_instr_out;
    setPc     = fetch_set_pc_out;
    pcOut     = fetch_pc_out;
    presented = fetch_instr_valid_in;
    @(posedge clk_in);
    #1;
    if (setPc) begin
      pendPc = pcOut; pendLag = fetchLag; pendValid = 1'b1;
    end
    if (pendValid && pendLag == 0) begin
      fpc = pendPc; pendValid = 1'b0;
    end else begin
      if (pendValid) pendLag--;
      if (presented) fpc += 32'd4;
    end
    driveFetch();
  endtask

  task automatic test_reset();
    logic hs; logic [31:0] hsPc, hsInstr;
    rst_low_in = 1'b0;
    repeat (2) applyStimulus(hs, hsPc, hsInstr);
    compared++; if (dec_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dec_valid: got %b, required 0", dec_valid_out); end
    compared++; if (dec_pc_out !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_dec_pc: got %h, required 0", dec_pc_out); end
    compared++; if (dec_instr_out !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_dec_instr: got %h, required 0", dec_instr_out); end
    compared++; if (misalign_err_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_misalign: got %b, required 0", misalign_err_out); end
    compared++; if (redirect_count_out !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_count: got %h, required 0", redirect_count_out); end
    compared++; if (fetch_set_pc_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_set_pc: got %b, required 0", fetch_set_pc_out); end
    compared++; if (fetch_pc_out !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_fetch_pc: got %h, required 0", fetch_pc_out); end
  endtask

  task automatic test_boot_stream();
    logic hs; logic [31:0] hsPc, hsInstr, expPc; int lastHs;
    rst_low_in = 1'b1; fetchOn = 1'b1; fetchStop = 32'h4C; driveFetch();
    #1;
    compared++;
    if (fetch_set_pc_out !== 1'b1 || fetch_pc_out !== 32'h40) begin
      mismatched++; $display("[TB] FAIL boot_set_pc: got set %b pc %h, required set 1 pc 00000040", fetch_set_pc_out, fetch_pc_out);
    end
    sbq.push_back(32'h40); sbq.push_back(32'h44); sbq.push_back(32'h48);
    lastHs = -1;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(hs, hsPc, hsInstr);
      if (hs) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++; $display("[TB] FAIL boot_sb: got pc %h, required no output", hsPc);
        end else begin
          expPc = sbq.pop_front();
          if (hsPc !== expPc || hsInstr !== wordFor(expPc)) begin
            mismatched++; $display("[TB] FAIL boot_sb: got pc %h instr %h, required pc %h instr %h", hsPc, hsInstr, expPc, wordFor(expPc));
          end
        end
        if (lastHs >= 0) begin
          compared++;
          if (c != lastHs + 1) begin mismatched++; $display("[TB] FAIL boot_gap: got cycle %0d, required %0d", c, lastHs + 1); end
        end
        lastHs = c;
      end
    end
    compared++; if (sbq.size() != 0) begin mismatched++; $display("[TB] FAIL boot_drain: got %0d outstanding, required 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_branch();
    logic hs; logic [31:0] hsPc, hsInstr, expPc;
    fetchStop = 32'h10C; fetchLag = 2; driveFetch();
    sbq.push_back(32'h100); sbq.push_back(32'h104); sbq.push_back(32'h108);
    for (int c = 0; c < 12; c++) begin
      dec_ready_in = (c != 1);
      if (c == 1) begin
        branch_req_in = 1'b1; branch_target_in = 32'h100;
        #1;
        compared++;
        if (fetch_set_pc_out !== 1'b1 || fetch_pc_out !== 32'h100) begin
          mismatched++; $display("[TB] FAIL branch_set_pc: got set %b pc %h, required set 1 pc 00000100", fetch_set_pc_out, fetch_pc_out);
        end
      end
      applyStimulus(hs, hsPc, hsInstr);
      branch_req_in = 1'b0;
      if (c == 1) begin
        compared++; if (dec_valid_out !== 1'b0) begin mismatched++; $display("[TB] FAIL branch_clear: got %b, required 0", dec_valid_out); end
        compared++; if (redirect_count_out !== 16'd1) begin mismatched++; $display("[TB] FAIL branch_count: got %0d, required 1", redirect_count_out); end
      end
      if (hs) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++; $display("[TB] FAIL branch_sb: got pc %h, required no output", hsPc);
        end else begin
          expPc = sbq.pop_front();
          if (hsPc !== expPc || hsInstr !== wordFor(expPc)) begin
            mismatched++; $display("[TB] FAIL branch_sb: got pc %h instr %h, required pc %h instr %h", hsPc, hsInstr, expPc, wordFor(expPc));
          end
        end
      end
    end
    fetchLag = 0; dec_ready_in = 1'b1;
    compared++; if (sbq.size() != 0) begin mismatched++; $display("[TB] FAIL branch_drain: got %0d outstanding, required 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_trap_priority();
    logic hs; logic [31:0] hsPc, hsInstr, expPc;
    fetchStop = 32'h208; driveFetch();
    sbq.push_back(32'h200); sbq.push_back(32'h204);
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        trap_req_in = 1'b1; trap_target_in = 32'h200;
        branch_req_in = 1'b1; branch_target_in = 32'h300;
        #1;
        compared++;
        if (fetch_set_pc_out !== 1'b1 || fetch_pc_out !== 32'h200) begin
          mismatched++; $display("[TB] FAIL trap_set_pc: got set %b pc %h, required set 1 pc 00000200", fetch_set_pc_out, fetch_pc_out);
        end
      end
      applyStimulus(hs, hsPc, hsInstr);
      trap_req_in = 1'b0; branch_req_in = 1'b0;
      if (c == 0) begin
        compared++; if (redirect_count_out !== 16'd2) begin mismatched++; $display("[TB] FAIL trap_count: got %0d, required 2", redirect_count_out); end
        compared++; if (misalign_err_out !== 1'b0) begin mismatched++; $display("[TB] FAIL trap_misalign: got %b, required 0", misalign_err_out); end
      end
      if (hs) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++; $display("[TB] FAIL trap_sb: got pc %h, required no output", hsPc);
        end else begin
          expPc = sbq.pop_front();
          if (hsPc !== expPc || hsInstr !== wordFor(expPc)) begin
            mismatched++; $display("[TB] FAIL trap_sb: got pc %h instr %h, required pc %h instr %h", hsPc, hsInstr, expPc, wordFor(expPc));
          end
        end
      end
    end
    compared++; if (sbq.size() != 0) begin mismatched++; $display("[TB] FAIL trap_drain: got %0d outstanding, required 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_stall();
    logic hs; logic [31:0] hsPc, hsInstr, expPc;
    fetchStop = 32'h1C; driveFetch();
    sbq.push_back(32'h10); sbq.push_back(32'h14); sbq.push_back(32'h18);
    for (int c = 0; c < 14; c++) begin
      dec_ready_in = !(c >= 2 && c <= 6);
      if (c == 0) begin branch_req_in = 1'b1; branch_target_in = 32'h10; end
      #1;
      if (c >= 2 && c <= 6) begin
        compared++;
        if (fetch_set_pc_out !== 1'b1 || fetch_pc_out !== 32'h14) begin
          mismatched++; $display("[TB] FAIL stall_refetch: got set %b pc %h, required set 1 pc 00000014", fetch_set_pc_out, fetch_pc_out);
        end
        compared++;
        if (dec_valid_out !== 1'b1 || dec_pc_out !== 32'h10) begin
          mismatched++; $display("[TB] FAIL stall_hold: got valid %b pc %h, required valid 1 pc 00000010", dec_valid_out, dec_pc_out);
        end
      end
      if (c == 7) begin
        compared++; if (fetch_set_pc_out !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_release: got set %b, required 0", fetch_set_pc_out); end
      end
      applyStimulus(hs, hsPc, hsInstr);
      branch_req_in = 1'b0;
      if (hs) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++; $display("[TB] FAIL stall_sb: got pc %h, required no output", hsPc);
        end else begin
          expPc = sbq.pop_front();
          if (hsPc !== expPc || hsInstr !== wordFor(expPc)) begin
            mismatched++; $display("[TB] FAIL stall_sb: got pc %h instr %h, required pc %h instr %h", hsPc, hsInstr, expPc, wordFor(expPc));
          end
        end
      end
    end
    compared++; if (sbq.size() != 0) begin mismatched++; $display("[TB] FAIL stall_drain: got %0d outstanding, required 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_misalign();
    logic hs; logic [31:0] hsPc, hsInstr, expPc;
    fetchStop = 32'h104; driveFetch();
    sbq.push_back(32'h100);
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin
        branch_req_in = 1'b1; branch_target_in = 32'h103;
        #1;
        compared++;
        if (fetch_set_pc_out !== 1'b1 || fetch_pc_out !== 32'h100) begin
          mismatched++; $display("[TB] FAIL misalign_pc: got set %b pc %h, required set 1 pc 00000100", fetch_set_pc_out, fetch_pc_out);
        end
      end
      applyStimulus(hs, hsPc, hsInstr);
      branch_req_in = 1'b0;
      if (c == 0) begin
        compared++; if (misalign_err_out !== 1'b1) begin mismatched++; $display("[TB] FAIL misalign_pulse: got %b, required 1", misalign_err_out); end
      end
      if (c == 1) begin
        compared++; if (misalign_err_out !== 1'b0) begin mismatched++; $display("[TB] FAIL misalign_width: got %b, required 0", misalign_err_out); end
      end
      if (hs) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++; $display("[TB] FAIL misalign_sb: got pc %h, required no output", hsPc);
        end else begin
          expPc = sbq.pop_front();
          if (hsPc !== expPc || hsInstr !== wordFor(expPc)) begin
            mismatched++; $display("[TB] FAIL misalign_sb: got pc %h instr %h, required pc %h instr %h", hsPc, hsInstr, expPc, wordFor(expPc));
          end
        end
      end
    end
    compared++; if (sbq.size() != 0) begin mismatched++; $display("[TB] FAIL misalign_drain: got %0d outstanding, required 0", sbq.size()); sbq.delete(); end
  endtask

  task automatic test_saturation();
    logic hs; logic [31:0] hsPc, hsInstr; int expCount;
    expCount = 4;
    fetchStop = 32'h400; driveFetch();
    compared++; if (redirect_count_out !== 16'd4) begin mismatched++; $display("[TB] FAIL sat_start: got %0d, required 4", redirect_count_out); end
    for (int n = 0; n < 65536; n++) begin
      branch_req_in = 1'b1; branch_target_in = 32'h400;
      applyStimulus(hs, hsPc, hsInstr);
      expCount++;
      if (hs) begin
        compared++; mismatched++; $display("[TB] FAIL sat_sb: got pc %h, required no output", hsPc);
      end
      if (expCount == 65534) begin
        compared++; if (redirect_count_out !== 16'hFFFE) begin mismatched++; $display("[TB] FAIL sat_below: got %h, required fffe", redirect_count_out); end
      end
      if (expCount == 65535) begin
        compared++; if (redirect_count_out !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL sat_reach: got %h, required ffff", redirect_count_out); end
      end
    end
    branch_req_in = 1'b0;
    applyStimulus(hs, hsPc, hsInstr);
    compared++; if (redirect_count_out !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL sat_hold: got %h after %0d redirects, required ffff", redirect_count_out, expCount); end
  endtask

  task automatic test_reset_in_stall();
    logic hs; logic [31:0] hsPc, hsInstr, expPc;
    fetchStop = 32'h50C; driveFetch();
    for (int c = 0; c < 4; c++) begin
      dec_ready_in = (c < 2);
      if (c == 0) begin branch_req_in = 1'b1; branch_target_in = 32'h500; end
      applyStimulus(hs, hsPc, hsInstr);
      branch_req_in = 1'b0;
      if (hs) begin
        compared++; mismatched++; $display("[TB] FAIL rstall_sb: got pc %h, required no output", hsPc);
      end
    end
    rst_low_in = 1'b0;
    #1;
    compared++; if (fetch_set_pc_out !== 1'b0) begin mismatched++; $display("[TB] FAIL rstall_set_pc: got %b, required 0", fetch_set_pc_out); end
    applyStimulus(hs, hsPc, hsInstr);
    compared++;
    if (dec_valid_out !== 1'b0 || dec_pc_out !== 32'h0 || dec_instr_out !== 32'h0 ||
        misalign_err_out !== 1'b0 || redirect_count_out !== 16'h0 || fetch_pc_out !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL rstall_clear: got valid %b pc %h instr %h mis %b cnt %h fpc %h, required all zero",
               dec_valid_out, dec_pc_out, dec_instr_out, misalign_err_out, redirect_count_out, fetch_pc_out);
    end
    rst_low_in = 1'b1; dec_ready_in = 1'b1; fetchStop = 32'h48; driveFetch();
    #1;
    compared++;
    if (fetch_set_pc_out !== 1'b1 || fetch_pc_out !== 32'h40) begin
      mismatched++; $display("[TB] FAIL rstall_boot: got set %b pc %h, required set 1 pc 00000040", fetch_set_pc_out, fetch_pc_out);
    end
    sbq.push_back(32'h40); sbq.push_back(32'h44);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(hs, hsPc, hsInstr);
      if (hs) begin
        compared++;
        if (sbq.size() == 0) begin
          mismatched++; $display("[TB] FAIL rstall_sb: got pc %h, required no output", hsPc);
        end else begin
          expPc = sbq.pop_front();
          if (hsPc !== expPc || hsInstr !== wordFor(expPc)) begin
            mismatched++; $display("[TB] FAIL rstall_sb: got pc %h instr %h, required pc %h instr %h", hsPc, hsInstr, expPc, wordFor(expPc));
          end
        end
      end
    end
    compared++; if (sbq.size() != 0) begin mismatched++; $display("[TB] FAIL rstall_drain: got %0d outstanding, required 0", sbq.size()); sbq.delete(); end
  endtask

  // Scenario sequence; each scenario leaves the fetcher parked for the next.
  initial begin
    rst_low_in = 1'b0; dec_ready_in = 1'b1;
    trap_req_in = 1'b0; trap_target_in = '0;
    branch_req_in = 1'b0; branch_target_in = '0;
    fpc = '0; fetchStop = '0; pendPc = '0; fetchLag = 0; pendLag = 0;
    pendValid = 1'b0; fetchOn = 1'b0;
    driveFetch();
    $display("[TB] starting fetch_redirect_ctrl scenarios");
    test_reset();
    test_boot_stream();
    test_branch();
    test_trap_priority();
    test_stall();
    test_misalign();
    test_saturation();
    test_reset_in_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
